// File: rtl/uart_pkg.sv
// uart_pkg: UART state encoding and bit-timing helpers shared by the RX and TX sides.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK
   } uart_state_e;

   function automatic int unsigned uart_cpb(input int unsigned clk_freq, input int unsigned baud);
      return clk_freq / baud;
   endfunction

   function automatic int unsigned uart_half(input int unsigned clk_freq, input int unsigned baud);
      return uart_cpb(clk_freq, baud) / 2;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous level, resets to 1 (idle line).
module sync_2ff (
   input  logic clk,
   input  logic rstn,
   input  logic d,
   output logic q
);

   logic [1:0] ff_q;

   always_ff @(posedge clk) begin
      if (!rstn) ff_q <= 2'b11;
      else       ff_q <= {ff_q[0], d};
   end

   assign q = ff_q[1];

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: 8-bit UART receiver with valid/ready holding register and error pulses.
// Define UART_RX_PARITY_EN for 8E1 framing with parity checking; default build is 8N1.
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ  = 100_000_000,
   parameter int unsigned BAUD_RATE = 9600
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       rxd,
   output logic [7:0] data,
   output logic       valid,
   input  logic       ready,
   output logic       busy,
   output logic       frame_err,
   output logic       overrun,
   output logic       parity_err
);

   localparam int unsigned CPB  = uart_cpb(CLK_FREQ, BAUD_RATE);
   localparam int unsigned HALF = uart_half(CLK_FREQ, BAUD_RATE);
   localparam int          TW   = (CPB < 4) ? 2 : $clog2(CPB);
`ifdef UART_RX_PARITY_EN
   localparam uart_state_e AFTER_DATA = ST_PARITY;
`else
   localparam uart_state_e AFTER_DATA = ST_STOP;
`endif

   typedef logic [TW-1:0] tmr_t;

   generate
      if (CPB < 4) begin : g_cpb_chk
         $error("uart_rx_ctrl: CLK_FREQ/BAUD_RATE must be at least 4");
      end
   endgenerate

   logic        rxd_s;
   uart_state_e state_q, state_d;
   tmr_t        timer_q, timer_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  shift_q, shift_d, data_q, data_d;
   logic        valid_q, valid_d, busy_q, busy_d, bad_q, bad_d;
   logic        frame_err_q, frame_err_d, overrun_q, overrun_d, parity_err_q, parity_err_d;
   logic [1:0]  settle_q, settle_d;
   logic        armed_q, armed_d;
   logic        tick;

   sync_2ff u_sync (.clk(clk), .rstn(rstn), .d(rxd), .q(rxd_s));

   assign tick = timer_q == tmr_t'(CPB - 1);

   // After reset the line is only trusted once the synchronizer has flushed and shown idle-high,
   // so a frame caught mid-flight cannot start a bogus reception.
   always_comb begin
      state_d      = state_q;
      timer_d      = tmr_t'(timer_q + 1'b1);
      idx_d        = idx_q;
      shift_d      = shift_q;
      data_d       = data_q;
      valid_d      = valid_q & ~ready;
      bad_d        = bad_q;
      frame_err_d  = 1'b0;
      overrun_d    = 1'b0;
      parity_err_d = 1'b0;
      settle_d     = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
      armed_d      = armed_q | ((settle_q == 2'd3) & rxd_s);
      case (state_q)
         ST_IDLE: begin
            timer_d = '0;
            state_d = (armed_q & ~rxd_s) ? ST_START : ST_IDLE;
         end
         ST_START: if (timer_q == tmr_t'(HALF - 1)) begin
            timer_d = '0;
            idx_d   = '0;
            bad_d   = 1'b0;
            state_d = rxd_s ? ST_IDLE : ST_DATA;
         end
         ST_DATA: if (tick) begin
            timer_d = '0;
            shift_d = {rxd_s, shift_q[7:1]};
            idx_d   = idx_q + 3'd1;
            state_d = (idx_q == 3'd7) ? AFTER_DATA : ST_DATA;
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: if (tick) begin
            timer_d      = '0;
            parity_err_d = rxd_s != ^shift_q;
            bad_d        = bad_q | parity_err_d;
            state_d      = ST_STOP;
         end
`endif
         ST_STOP: if (tick) begin
            timer_d     = '0;
            frame_err_d = ~rxd_s;
            state_d     = rxd_s ? ST_IDLE : ST_BREAK;
            if (rxd_s && !bad_q) begin
               data_d    = (!valid_q || ready) ? shift_q : data_q;
               valid_d   = valid_d | !valid_q | ready;
               overrun_d = valid_q & ~ready;
            end
         end
         ST_BREAK: begin
            timer_d = '0;
            state_d = rxd_s ? ST_IDLE : ST_BREAK;
         end
         default: begin
            timer_d = '0;
            state_d = ST_IDLE;
         end
      endcase
      busy_d = state_d != ST_IDLE;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q      <= ST_IDLE;
         timer_q      <= '0;
         idx_q        <= '0;
         shift_q      <= '0;
         data_q       <= '0;
         valid_q      <= 1'b0;
         busy_q       <= 1'b0;
         bad_q        <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
         parity_err_q <= 1'b0;
         settle_q     <= '0;
         armed_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         idx_q        <= idx_d;
         shift_q      <= shift_d;
         data_q       <= data_d;
         valid_q      <= valid_d;
         busy_q       <= busy_d;
         bad_q        <= bad_d;
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
         parity_err_q <= parity_err_d;
         settle_q     <= settle_d;
         armed_q      <= armed_d;
      end
   end

   assign data       = data_q;
   assign valid      = valid_q;
   assign busy       = busy_q;
   assign frame_err  = frame_err_q;
   assign overrun    = overrun_q;
   assign parity_err = parity_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: scoreboard bench for uart_rx_ctrl at CPB=10, HALF=5.
module tb_uart_rx_ctrl;

   localparam int CPB = 10;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       rxd = 1'b1;
   logic       ready = 1'b0;
   logic [7:0] data;
   logic       valid, busy, frame_err, overrun, parity_err;

   int         n_run = 0, n_fail = 0;
   int         cyc = 0;
   int         n_fe = 0, n_ov = 0, n_pe = 0, n_valid_hi = 0, n_busy = 0;
   int         t_start = 0, t_valid = -1, t_busy_last = -1;
   logic       valid_prev = 1'b0;
   logic [7:0] exp_q[$];

   uart_rx_ctrl #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000)) dut (
      .clk(clk), .rstn(rstn), .rxd(rxd), .data(data), .valid(valid), .ready(ready),
      .busy(busy), .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rstn) begin
         n_fe       += int'(frame_err);
         n_ov       += int'(overrun);
         n_pe       += int'(parity_err);
         n_valid_hi += int'(valid);
         n_busy     += int'(busy);
         if (busy) t_busy_last = cyc;
         if (valid && !valid_prev) t_valid = cyc;
         if (valid && ready) begin
            if (exp_q.size() == 0) check("unexpected_valid", {24'd0, data}, 32'hffff_ffff);
            else check("data", {24'd0, data}, {24'd0, exp_q.pop_front()});
         end
      end
      valid_prev = valid;
   end

   task automatic clr();
      n_fe = 0; n_ov = 0; n_pe = 0; n_valid_hi = 0; n_busy = 0; t_valid = -1; t_busy_last = -1;
   endtask

   task automatic line(input logic v, input int n);
      rxd = v;
      repeat (n) @(negedge clk);
   endtask

   // start + 8 data bits (+ parity when par >= 0); caller drives the stop bit
   task automatic frame(input logic [7:0] b, input int par);
      t_start = cyc;
      line(1'b0, CPB);
      for (int i = 0; i < 8; i++) line(b[i], CPB);
      if (par >= 0) line(par[0], CPB);
   endtask

   task automatic send(input logic [7:0] b, input int par);
      frame(b, par);
      line(1'b1, 2 * CPB);
   endtask

`ifdef UART_RX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = -1;
`endif

   initial begin
      int lat;
      repeat (3) @(negedge clk);
      check("rst_valid", {31'd0, valid}, 0);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_data", {24'd0, data}, 0);
      check("rst_pulses", {29'd0, frame_err, overrun, parity_err}, 0);
      rstn = 1'b1;
      repeat (10) @(negedge clk);

      ready = 1'b1;
      clr();
      exp_q.push_back(8'hA5);
      send(8'hA5, (PB < 0) ? -1 : int'(^8'hA5));
      lat = t_valid - t_start;
      check($sformatf("a5_latency_%0d", lat), {31'd0, (lat >= 96 + (PB > 0 ? CPB : 0)) && (lat <= 98 + (PB > 0 ? CPB : 0))}, 1);
      check("a5_valid_cycles", n_valid_hi, 1);
      check("a5_errors", n_fe + n_ov + n_pe, 0);
      check("a5_consumed", exp_q.size(), 0);

      ready = 1'b0;
      clr();
      exp_q.push_back(8'h3C);
      send(8'h3C, (PB < 0) ? -1 : int'(^8'h3C));
      send(8'h81, (PB < 0) ? -1 : int'(^8'h81));
      check("ovr_data_held", {24'd0, data}, 32'h3C);
      check("ovr_valid_held", {31'd0, valid}, 1);
      check("ovr_pulses", n_ov, 1);
      check("ovr_no_fe", n_fe, 0);
      ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("ovr_valid_drop", {31'd0, valid}, 0);
      check("ovr_consumed", exp_q.size(), 0);

      clr();
      t_start = cyc;
      line(1'b0, 3);
      line(1'b1, 20);
      check("glitch_busy_seen", {31'd0, n_busy > 0}, 1);
      check($sformatf("glitch_busy_end_%0d", t_busy_last - t_start), {31'd0, (t_busy_last - t_start >= 6) && (t_busy_last - t_start <= 8)}, 1);
      check("glitch_no_valid", n_valid_hi, 0);
      check("glitch_idle", {31'd0, busy}, 0);

      clr();
      frame(8'h55, (PB < 0) ? -1 : int'(^8'h55));
      line(1'b0, 30);
      check("brk_busy", {31'd0, busy}, 1);
      check("brk_fe_pulses", n_fe, 1);
      line(1'b1, 5);
      check("brk_exit", {31'd0, busy}, 0);
      check("brk_no_valid", n_valid_hi, 0);
      exp_q.push_back(8'h12);
      send(8'h12, (PB < 0) ? -1 : int'(^8'h12));
      check("brk_12_consumed", exp_q.size(), 0);

      line(1'b0, CPB);
      line(1'b0, 3 * CPB);
      rstn = 1'b0;
      @(negedge clk);
      check("mid_rst_outputs", {data, valid, busy, frame_err, overrun, parity_err}, 0);
      rstn = 1'b1;
      clr();
      line(1'b0, 5 * CPB - 1 + (PB > 0 ? CPB : 0));
      line(1'b1, 3 * CPB);
      check("mid_rst_ignored", n_valid_hi + n_fe, 0);
      exp_q.push_back(8'hFF);
      send(8'hFF, (PB < 0) ? -1 : int'(^8'hFF));
      check("ff_consumed", exp_q.size(), 0);

`ifdef UART_RX_PARITY_EN
      clr();
      send(8'h07, 0);
      check("par_err_pulse", n_pe, 1);
      check("par_no_valid", n_valid_hi, 0);
      exp_q.push_back(8'h07);
      send(8'h07, 1);
      check("par_ok_no_err", n_pe, 1);
      check("par_consumed", exp_q.size(), 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
